// File: rtl/ripple_counter_d_ff_pkg.sv
// Shared constants for the D-FF counter library.
package ripple_counter_d_ff_pkg;

    // Default stage count for a counter instance.
    localparam int DEFAULT_WIDTH = 3;

    // Supported stage-count range; the carry chain is unbuffered,
    // so wider counters need a lookahead structure instead.
    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 16;

endpackage

// File: rtl/ripple_counter_d_ff_d_ff_sr.sv
// Single-bit D flip-flop with synchronous active-low clear.
module d_ff_sr (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    // Capture d on every rising edge; clr low forces the stage to 0.
    always_ff @(posedge clk) begin
        if (!clr) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/ripple_counter_d_ff.sv
// Free-running wrapping up-counter built from one D flip-flop per bit.
// A combinational toggle chain decides which stages flip on each edge;
// all stages share clk, so every bit of q updates on the same edge.
module ripple_counter_d_ff
    import ripple_counter_d_ff_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] d;

    // Toggle chain: a stage flips only when every lower stage is 1.
    always_comb begin
        t    = '0;
        t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t[i] = t[i-1] & q[i-1];
        end
        d = q ^ t;
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_stage
        d_ff_sr u_stage (
            .clk (clk),
            .clr (clr),
            .d   (d[g]),
            .q   (q[g])
        );
    end

endmodule

// File: tb/tb_ripple_counter_d_ff.sv
// Directed bench for ripple_counter_d_ff at WIDTH = 3, 4 and 1.
module tb_ripple_counter_d_ff;

    logic       clk;
    logic       clr;
    logic [2:0] q3;
    logic [3:0] q4;
    logic [0:0] q1;

    int total_cnt;
    int pass_cnt;

    ripple_counter_d_ff #(.WIDTH(3)) u_dut3 (.clk(clk), .clr(clr), .q(q3));
    ripple_counter_d_ff #(.WIDTH(4)) u_dut4 (.clk(clk), .clr(clr), .q(q4));
    ripple_counter_d_ff #(.WIDTH(1)) u_dut1 (.clk(clk), .clr(clr), .q(q1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b0;
        step();
        clr = 1'b1;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if (q3 !== 3'd0) $display("FAIL reset_w3 edge %0d: got %0d expected 0", i, q3);
            else pass_cnt++;
            total_cnt++;
            if (q4 !== 4'd0) $display("FAIL reset_w4 edge %0d: got %0d expected 0", i, q4);
            else pass_cnt++;
            total_cnt++;
            if (q1 !== 1'b0) $display("FAIL reset_w1 edge %0d: got %0d expected 0", i, q1);
            else pass_cnt++;
        end
    endtask

    task automatic test_full_sequence();
        logic [2:0] exp_tab [8];
        exp_tab = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            total_cnt++;
            if (q3 !== exp_tab[i]) $display("FAIL full_seq edge %0d: got %0d expected %0d", i, q3, exp_tab[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_long_run();
        logic [2:0] exp3;
        logic [2:0] early;
        do_reset();
        exp3 = 3'd0;
        for (int n = 1; n <= 50; n++) begin
            step();
            exp3 = exp3 + 3'd1;
            early = q3;
            total_cnt++;
            if (q3 !== exp3) $display("FAIL long_run edge %0d: got %0d expected %0d", n, q3, exp3);
            else pass_cnt++;
            #7;
            total_cnt++;
            if (q3 !== early) $display("FAIL long_run_stable edge %0d: got %0d expected %0d", n, q3, early);
            else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 5; i++) step();
        total_cnt++;
        if (q3 !== 3'd5) $display("FAIL mid_reset_pre: got %0d expected 5", q3);
        else pass_cnt++;
        clr = 1'b0;
        step();
        total_cnt++;
        if (q3 !== 3'd0) $display("FAIL mid_reset_clear: got %0d expected 0", q3);
        else pass_cnt++;
        clr = 1'b1;
        step();
        total_cnt++;
        if (q3 !== 3'd1) $display("FAIL mid_reset_resume: got %0d expected 1", q3);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        do_reset();
        for (int i = 0; i < 3; i++) step();
        total_cnt++;
        if (q3 !== 3'd3) $display("FAIL glitch_pre: got %0d expected 3", q3);
        else pass_cnt++;
        #2;
        clr = 1'b0;
        #2;
        clr = 1'b1;
        step();
        total_cnt++;
        if (q3 !== 3'd4) $display("FAIL glitch_post: got %0d expected 4", q3);
        else pass_cnt++;
    endtask

    task automatic test_width_params();
        logic [3:0] exp4_tab [17];
        logic       exp1_tab [17];
        exp4_tab = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                     4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1};
        exp1_tab = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                     1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step();
            total_cnt++;
            if (q4 !== exp4_tab[i]) $display("FAIL width4 edge %0d: got %0d expected %0d", i, q4, exp4_tab[i]);
            else pass_cnt++;
            total_cnt++;
            if (q1 !== exp1_tab[i]) $display("FAIL width1 edge %0d: got %0d expected %0d", i, q1, exp1_tab[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        clr       = 1'b1;
        #2;
        test_reset();
        test_full_sequence();
        test_long_run();
        test_mid_reset();
        test_glitch();
        test_width_params();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
